// File: rtl/day_pkg.sv
// Shared types for the multi-channel accumulator: fold modes, control states
// and the per-mode identity helper.
package day_pkg;

    typedef enum logic [1:0] {
        MODE_SUM  = 2'b00,
        MODE_MAX  = 2'b01,
        MODE_MIN  = 2'b10,
        MODE_RSVD = 2'b11
    } mode_t;

    typedef enum logic [1:0] {
        ACCUM = 2'b00,
        DRAIN = 2'b01,
        DONE  = 2'b10
    } state_t;

    // Min folds start from all-ones; every other mode starts from zero.
    function automatic logic identity_is_ones(input mode_t m);
        return (m == MODE_MIN);
    endfunction

endpackage

// File: rtl/day_acc_lane.sv
// One accumulator channel: folds accepted values by mode and keeps a sticky
// overflow flag for saturating sums.
module day_acc_lane
    import day_pkg::*;
#(
    parameter int IN_W  = 32,
    parameter int ACC_W = 64
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             init,
    input  logic             accept,
    input  mode_t            mode,
    input  logic [IN_W-1:0]  data,
    output logic [ACC_W-1:0] acc,
    output logic             overflow
);

    logic [ACC_W-1:0] data_ext;
    logic [ACC_W:0]   sum;

    always_comb begin
        data_ext = ACC_W'(data);
        sum      = {1'b0, acc} + {1'b0, data_ext};
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            acc      <= '0;
            overflow <= 1'b0;
        end else if (init) begin
            acc      <= identity_is_ones(mode) ? '1 : '0;
            overflow <= 1'b0;
        end else if (accept) begin
            case (mode)
                MODE_MAX: if (data_ext > acc) acc <= data_ext;
                MODE_MIN: if (data_ext < acc) acc <= data_ext;
                default: begin
                    if (sum[ACC_W]) begin
                        acc      <= '1;
                        overflow <= 1'b1;
                    end else begin
                        acc <= sum[ACC_W-1:0];
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/day_multi_accumulator.sv
// Streaming multi-channel accumulator: folds items per channel, then drains
// one channel result per handshake and parks in DONE until reloaded.
module day_multi_accumulator
    import day_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int IN_W   = 32,
    parameter int ACC_W  = 64,
    parameter int CNT_W  = 32,
    localparam int CH_W  = $clog2((NUM_CH > 1) ? NUM_CH : 2)
) (
    input  logic                   clock,
    input  logic                   clear,
    input  logic                   load,
    input  logic [1:0]             mode,
    input  logic                   item_valid,
    input  logic                   item_last,
    input  logic [NUM_CH*IN_W-1:0] item_data,
    output logic                   ready,
    output logic                   done_,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [CH_W-1:0]        res_channel,
    output logic [ACC_W-1:0]       res_data,
    output logic                   res_overflow,
    output logic [CNT_W-1:0]       item_count
);

    state_t           state;
    mode_t            mode_q;
    mode_t            lane_mode;
    logic [CH_W-1:0]  idx;
    logic             accept;
    logic [ACC_W-1:0] acc_bus [NUM_CH];
    logic             ovf_bus [NUM_CH];

    // The lanes see the incoming mode during load so the identity matches it.
    always_comb begin
        lane_mode = load ? mode_t'(mode) : mode_q;
        accept    = item_valid & ready & ~load;
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
        day_acc_lane #(
            .IN_W  (IN_W),
            .ACC_W (ACC_W)
        ) u_lane (
            .clock    (clock),
            .clear    (clear),
            .init     (load),
            .accept   (accept),
            .mode     (lane_mode),
            .data     (item_data[c*IN_W +: IN_W]),
            .acc      (acc_bus[c]),
            .overflow (ovf_bus[c])
        );
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            state      <= ACCUM;
            mode_q     <= MODE_SUM;
            idx        <= '0;
            item_count <= '0;
        end else if (load) begin
            state      <= ACCUM;
            mode_q     <= mode_t'(mode);
            idx        <= '0;
            item_count <= '0;
        end else begin
            case (state)
                ACCUM: begin
                    if (accept) begin
                        if (item_count != '1) item_count <= item_count + CNT_W'(1);
                        if (item_last) state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (res_ready) begin
                        if (idx == CH_W'(NUM_CH - 1)) state <= DONE;
                        else                          idx   <= idx + CH_W'(1);
                    end
                end
                default: state <= DONE;
            endcase
        end
    end

    always_comb begin
        ready        = (state == ACCUM);
        done_        = (state == DONE);
        res_valid    = (state == DRAIN);
        res_channel  = idx;
        res_data     = res_valid ? acc_bus[idx] : '0;
        res_overflow = res_valid ? ovf_bus[idx] : 1'b0;
    end

endmodule

// File: tb/tb_day_multi_accumulator.sv
// Directed bench for day_multi_accumulator: a default-width instance and an
// 8-bit instance for saturation and min-identity cases.
module tb_day_multi_accumulator;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Default-parameter instance
    logic        clear, load, item_valid, item_last, res_ready;
    logic [1:0]  mode;
    logic [63:0] item_data;
    logic        ready, done_, res_valid, res_overflow;
    logic [0:0]  res_channel;
    logic [63:0] res_data;
    logic [31:0] item_count;

    day_multi_accumulator dut (
        .clock        (clock),
        .clear        (clear),
        .load         (load),
        .mode         (mode),
        .item_valid   (item_valid),
        .item_last    (item_last),
        .item_data    (item_data),
        .ready        (ready),
        .done_        (done_),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_channel  (res_channel),
        .res_data     (res_data),
        .res_overflow (res_overflow),
        .item_count   (item_count)
    );

    // Narrow instance
    logic        b_clear, b_load, b_item_valid, b_item_last, b_res_ready;
    logic [1:0]  b_mode;
    logic [15:0] b_item_data;
    logic        b_ready, b_done, b_res_valid, b_res_overflow;
    logic [0:0]  b_res_channel;
    logic [7:0]  b_res_data;
    logic [31:0] b_item_count;

    day_multi_accumulator #(
        .NUM_CH (2),
        .IN_W   (8),
        .ACC_W  (8),
        .CNT_W  (32)
    ) dut8 (
        .clock        (clock),
        .clear        (b_clear),
        .load         (b_load),
        .mode         (b_mode),
        .item_valid   (b_item_valid),
        .item_last    (b_item_last),
        .item_data    (b_item_data),
        .ready        (b_ready),
        .done_        (b_done),
        .res_valid    (b_res_valid),
        .res_ready    (b_res_ready),
        .res_channel  (b_res_channel),
        .res_data     (b_res_data),
        .res_overflow (b_res_overflow),
        .item_count   (b_item_count)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_load(input logic [1:0] m);
        load = 1'b1;
        mode = m;
        tick();
        load = 1'b0;
    endtask

    task automatic send(input logic [31:0] d0, input logic [31:0] d1, input logic last);
        item_valid = 1'b1;
        item_last  = last;
        item_data  = {d1, d0};
        tick();
        item_valid = 1'b0;
        item_last  = 1'b0;
    endtask

    task automatic b_send(input logic [7:0] d0, input logic [7:0] d1, input logic last);
        b_item_valid = 1'b1;
        b_item_last  = last;
        b_item_data  = {d1, d0};
        tick();
        b_item_valid = 1'b0;
        b_item_last  = 1'b0;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_ready"}, 64'(ready), 64'd1);
        check({tag, "_done"}, 64'(done_), 64'd0);
        check({tag, "_res_valid"}, 64'(res_valid), 64'd0);
        check({tag, "_res_channel"}, 64'(res_channel), 64'd0);
        check({tag, "_res_data"}, res_data, 64'd0);
        check({tag, "_res_ovf"}, 64'(res_overflow), 64'd0);
        check({tag, "_count"}, 64'(item_count), 64'd0);
    endtask

    initial begin
        clear = 1'b1; load = 1'b0; mode = 2'b00; item_valid = 1'b0;
        item_last = 1'b0; item_data = '0; res_ready = 1'b0;
        b_clear = 1'b1; b_load = 1'b0; b_mode = 2'b00; b_item_valid = 1'b0;
        b_item_last = 1'b0; b_item_data = '0; b_res_ready = 1'b0;
        tick();
        clear = 1'b0;
        b_clear = 1'b0;
        check_reset("rst");

        // 1: sum mode, free-running consumer
        res_ready = 1'b1;
        do_load(2'b00);
        send(3, 5, 1'b0);
        send(10, 20, 1'b0);
        check("t1_ready_mid", 64'(ready), 64'd1);
        send(7, 1, 1'b1);
        check("t1_ready_after_last", 64'(ready), 64'd0);
        check("t1_valid_ch0", 64'(res_valid), 64'd1);
        check("t1_chan0", 64'(res_channel), 64'd0);
        check("t1_data_ch0", res_data, 64'd20);
        check("t1_ovf_ch0", 64'(res_overflow), 64'd0);
        check("t1_count", 64'(item_count), 64'd3);
        tick();
        check("t1_chan1", 64'(res_channel), 64'd1);
        check("t1_data_ch1", res_data, 64'd26);
        check("t1_ovf_ch1", 64'(res_overflow), 64'd0);
        check("t1_done_low", 64'(done_), 64'd0);
        tick();
        check("t1_done", 64'(done_), 64'd1);
        check("t1_valid_off", 64'(res_valid), 64'd0);

        // 2: max then min over 4,9,2
        res_ready = 1'b0;
        do_load(2'b01);
        send(4, 0, 1'b0);
        send(9, 0, 1'b0);
        send(2, 0, 1'b1);
        check("t2_max_ch0", res_data, 64'd9);
        res_ready = 1'b0;
        do_load(2'b10);
        send(4, 0, 1'b0);
        send(9, 0, 1'b0);
        send(2, 0, 1'b1);
        check("t2_min_ch0", res_data, 64'd2);

        // 3: saturation and min identity on the 8-bit instance
        b_res_ready = 1'b1;
        b_load = 1'b1; b_mode = 2'b00; tick(); b_load = 1'b0;
        b_send(200, 10, 1'b0);
        b_send(100, 20, 1'b1);
        check("t3_sat_data", 64'(b_res_data), 64'd255);
        check("t3_sat_ovf", 64'(b_res_overflow), 64'd1);
        tick();
        check("t3_ch1_data", 64'(b_res_data), 64'd30);
        check("t3_ch1_ovf", 64'(b_res_overflow), 64'd0);
        tick();
        check("t3_done", 64'(b_done), 64'd1);
        b_load = 1'b1; b_mode = 2'b10; tick(); b_load = 1'b0;
        b_send(255, 255, 1'b1);
        check("t3_min_ones", 64'(b_res_data), 64'd255);
        check("t3_min_ovf", 64'(b_res_overflow), 64'd0);

        // 4: backpressure during drain
        res_ready = 1'b0;
        do_load(2'b00);
        send(1, 2, 1'b0);
        send(3, 4, 1'b1);
        for (int i = 0; i < 3; i++) begin
            check("t4_hold_valid", 64'(res_valid), 64'd1);
            check("t4_hold_chan", 64'(res_channel), 64'd0);
            check("t4_hold_data", res_data, 64'd4);
            tick();
        end
        res_ready = 1'b1;
        tick();
        check("t4_ch1_data", res_data, 64'd6);
        check("t4_ch1_chan", 64'(res_channel), 64'd1);
        res_ready = 1'b0;
        tick();
        check("t4_ch1_held", 64'(res_channel), 64'd1);
        check("t4_done_wait", 64'(done_), 64'd0);
        res_ready = 1'b1;
        tick();
        check("t4_done", 64'(done_), 64'd1);
        check("t4_valid_off", 64'(res_valid), 64'd0);

        // 5: load aborts drain, colliding item ignored; DONE ignores items
        res_ready = 1'b0;
        do_load(2'b00);
        send(7, 8, 1'b1);
        check("t5_in_drain", 64'(res_valid), 64'd1);
        load = 1'b1; mode = 2'b00;
        item_valid = 1'b1; item_data = {32'd60, 32'd50};
        tick();
        load = 1'b0; item_valid = 1'b0;
        check("t5_abort_valid", 64'(res_valid), 64'd0);
        check("t5_abort_ready", 64'(ready), 64'd1);
        check("t5_abort_count", 64'(item_count), 64'd0);
        send(0, 0, 1'b1);
        check("t5_acc0_zero", res_data, 64'd0);
        check("t5_count_one", 64'(item_count), 64'd1);
        res_ready = 1'b1;
        tick();
        check("t5_acc1_zero", res_data, 64'd0);
        tick();
        item_valid = 1'b1; item_data = {32'd9, 32'd9};
        tick();
        tick();
        item_valid = 1'b0;
        check("t5_done_count", 64'(item_count), 64'd1);
        check("t5_done_ready", 64'(ready), 64'd0);
        check("t5_done_hold", 64'(done_), 64'd1);

        // 6: clear mid-run; mode falls back to sum
        res_ready = 1'b0;
        do_load(2'b01);
        send(1, 1, 1'b0);
        send(2, 2, 1'b0);
        check("t6_count2", 64'(item_count), 64'd2);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check_reset("t6");
        send(5, 6, 1'b0);
        send(7, 8, 1'b1);
        check("t6_sum_mode", res_data, 64'd12);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
